pulse_window_cntr: RTL

- Counts single-cycle event pulses over a programmable window of clock cycles and presents each result through a valid/ack handshake.
- Sits in the destination clock domain, directly downstream of pulse_toggle_sync: its pulse_in is driven by pulse_out of that synchronizer.
- Typical uses are event-rate and frame-rate measurement of cross-domain strobes for register readback.

---
 rtl/pulse_window_cntr.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pulse_window_cntr.sv
// ---------------------------------------------------------------------------
// pulse_window_cntr
//
// Counts single-cycle event strobes over a programmable window of clock
// cycles and presents each completed count through a valid/ack handshake.
// Lives in the destination clock domain, fed by a pulse synchroniser, and is
// typically used to measure event or frame rates for register readback.
//
// Parameters:
//   MODULE_NAME  instance identification string
//   CNTR_W       width of the event accumulator and of cnt_out
//   WINDOW_W     width of window_len and of the window timer
//
// Ports:
//   clk         block clock
//   rst_n       asynchronous active-low reset
//   pulse_in    event strobe, each high cycle is one event
//   window_len  window length in clk cycles (sampled at start and at reload)
//   start       level request to begin measuring, honoured only when idle
//   continuous  at window end, start the next window back-to-back
//   abort       drop the window in progress without producing a result
//   busy        high whenever the block is not idle
//   cnt_out     count of the last completed window
//   cnt_ovrflw  accumulator saturated during the window shown on cnt_out
//   cnt_valid   result available, held until acknowledged
//   cnt_ack     consumer acknowledge, clears cnt_valid
//   missed      sticky, a result was overwritten before being acknowledged
// ---------------------------------------------------------------------------
module pulse_window_cntr #(
  parameter     MODULE_NAME = "PULSE_WINDOW_CNTR",
  parameter int CNTR_W      = 16,
  parameter int WINDOW_W    = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse_in,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  output logic                busy,
  output logic [CNTR_W-1:0]   cnt_out,
  output logic                cnt_ovrflw,
  output logic                cnt_valid,
  input  logic                cnt_ack,
  output logic                missed
);

  // Elaboration-time sanity check on the parameters.
  if (CNTR_W < 1 || WINDOW_W < 1 || MODULE_NAME == "") begin : g_param_check
    $error("pulse_window_cntr: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [WINDOW_W-1:0] timer;
  logic [CNTR_W-1:0]   accum;
  logic                ovf;

  logic [CNTR_W-1:0]   accum_next;
  logic                ovf_next;
  logic                last_edge;
  logic                reload_ok;

  // Saturating accumulate: once all-ones, further events are lost and
  // flagged rather than wrapping back to a small, misleading count.
  always_comb begin
    accum_next = accum;
    ovf_next   = ovf;
    if (pulse_in) begin
      if (&accum) begin
        ovf_next = 1'b1;
      end else begin
        accum_next = accum + CNTR_W'(1);
      end
    end
  end

  // The timer holds the number of window edges still to come, so the edge
  // that sees it at 1 is the last edge of the window.
  assign last_edge = (timer == WINDOW_W'(1));
  assign reload_ok = continuous && (window_len != '0);

  assign busy = (state != IDLE);

  // Single control process. The handshake clear is written first so that a
  // result loading on the same edge takes precedence and keeps cnt_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      accum      <= '0;
      ovf        <= 1'b0;
      cnt_out    <= '0;
      cnt_ovrflw <= 1'b0;
      cnt_valid  <= 1'b0;
      missed     <= 1'b0;
    end else begin
      if (cnt_ack && cnt_valid) begin
        cnt_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && (window_len != '0)) begin
            state  <= COUNT;
            timer  <= window_len;
            accum  <= '0;
            ovf    <= 1'b0;
            missed <= 1'b0;
          end
        end

        COUNT: begin
          if (abort) begin
            // Abort wins over a coinciding window end; the published
            // result and its handshake state are left alone.
            state <= IDLE;
            timer <= '0;
            accum <= '0;
            ovf   <= 1'b0;
          end else if (last_edge) begin
            // A pulse on the final edge still belongs to this window.
            cnt_out    <= accum_next;
            cnt_ovrflw <= ovf_next;
            cnt_valid  <= 1'b1;
            if (cnt_valid && !cnt_ack) begin
              missed <= 1'b1;
            end
            accum <= '0;
            ovf   <= 1'b0;
            if (reload_ok) begin
              timer <= window_len;
            end else begin
              timer <= '0;
              state <= DRAIN;
            end
          end else begin
            timer <= timer - WINDOW_W'(1);
            accum <= accum_next;
            ovf   <= ovf_next;
          end
        end

        DRAIN: begin
          if (!cnt_valid) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
